// File: rtl/memwb_stage_n.sv
// MEM/WB pipeline register with a data-memory sequencer for direct and pointer-indirect accesses.
// Latency: 1 cycle for non-memory ops, 1+(ind+1)*resp_delay for memory ops; request held until mem_resp.
module memwb_stage_n #(
  parameter int DATA_W     = 16,
  parameter int REG_W      = 3,
  parameter int IND_LEVELS = 1
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              advance,
  input  logic                              flush,
  input  logic                              valid_in,
  input  logic [DATA_W-1:0]                 pc_in,
  input  logic [REG_W-1:0]                  dest_in,
  input  logic [DATA_W-1:0]                 alu_in,
  input  logic [DATA_W-1:0]                 wdata_in,
  input  logic                              mem_read_in,
  input  logic                              mem_write_in,
  input  logic [$clog2(IND_LEVELS+1)-1:0]   ind_in,
  input  logic                              mem_resp,
  input  logic [DATA_W-1:0]                 mem_rdata,
  output logic                              valid_out,
  output logic [DATA_W-1:0]                 pc_out,
  output logic [REG_W-1:0]                  dest_out,
  output logic [DATA_W-1:0]                 result_out,
  output logic                              mem_req,
  output logic                              mem_we,
  output logic [DATA_W-1:0]                 mem_addr,
  output logic [DATA_W-1:0]                 mem_wdata,
  output logic                              ready,
  output logic [$clog2(IND_LEVELS+1)-1:0]   ind_left
);

  localparam int IW = $clog2(IND_LEVELS + 1);
  localparam logic [IW-1:0] IND_MAX = IW'(IND_LEVELS);
  localparam logic [IW-1:0] IND_ONE = IW'(1);

  typedef enum logic [1:0] {IDLE, DONE, PTR, FINAL} state_t;

  state_t            state, state_nxt;
  logic              valid_r, rd_r, wr_r;
  logic [DATA_W-1:0] pc_r, wdata_r, addr_r, result_r;
  logic [REG_W-1:0]  dest_r;
  logic [IW-1:0]     ind_r;
  logic [IW-1:0]     ind_sat;
  logic              mem_op;

  assign ind_sat = (ind_in > IND_MAX) ? IND_MAX : ind_in;
  assign mem_op  = valid_in && (mem_read_in || mem_write_in);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Priority: advance > flush > mem_resp; responses outside PTR/FINAL are dropped.
  always_comb begin
    state_nxt = state;
    if (advance) begin
      if (!mem_op)           state_nxt = DONE;
      else if (ind_sat != '0) state_nxt = PTR;
      else                   state_nxt = FINAL;
    end else if (flush) begin
      state_nxt = DONE;
    end else if (mem_resp) begin
      case (state)
        PTR:     if (ind_r == IND_ONE) state_nxt = FINAL;
        FINAL:   state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_r  <= 1'b0;
      rd_r     <= 1'b0;
      wr_r     <= 1'b0;
      pc_r     <= '0;
      dest_r   <= '0;
      wdata_r  <= '0;
      addr_r   <= '0;
      result_r <= '0;
      ind_r    <= '0;
    end else if (advance) begin
      valid_r  <= valid_in;
      rd_r     <= mem_read_in;
      wr_r     <= mem_write_in;
      pc_r     <= pc_in;
      dest_r   <= dest_in;
      wdata_r  <= wdata_in;
      addr_r   <= alu_in;
      result_r <= alu_in;
      ind_r    <= ind_sat;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (mem_resp) begin
      if (state == PTR) begin
        addr_r <= mem_rdata;
        ind_r  <= ind_r - IND_ONE;
      end else if (state == FINAL && rd_r) begin
        result_r <= mem_rdata;
      end
    end
  end

  // Request lines decode straight from state so an async reset drops them immediately.
  assign mem_req    = (state == PTR) || (state == FINAL);
  assign mem_we     = (state == FINAL) && wr_r;
  assign mem_addr   = addr_r;
  assign mem_wdata  = wdata_r;
  assign ready      = (state == DONE);
  assign valid_out  = valid_r;
  assign pc_out     = pc_r;
  assign dest_out   = dest_r;
  assign result_out = result_r;
  assign ind_left   = ind_r;

endmodule

// File: tb/tb_memwb_stage_n.sv
// Directed bench for memwb_stage_n: one default build plus an IND_LEVELS=2 build for saturation.
module tb_memwb_stage_n;

  logic        clk = 1'b0;
  logic        reset_n, advance, adv2, flush, valid_in, mem_read_in, mem_write_in, mem_resp;
  logic [15:0] pc_in, alu_in, wdata_in, mem_rdata;
  logic [2:0]  dest_in;
  logic        ind1;
  logic [1:0]  ind2;

  logic        valid_out, mem_req, mem_we, ready, ind_left;
  logic [15:0] pc_out, result_out, mem_addr, mem_wdata;
  logic [2:0]  dest_out;

  logic        valid_out2, mem_req2, mem_we2, ready2;
  logic [1:0]  ind_left2;
  logic [15:0] pc_out2, result_out2, mem_addr2, mem_wdata2;
  logic [2:0]  dest_out2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  memwb_stage_n u_dut (
    .clk(clk), .reset_n(reset_n), .advance(advance), .flush(flush), .valid_in(valid_in),
    .pc_in(pc_in), .dest_in(dest_in), .alu_in(alu_in), .wdata_in(wdata_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .ind_in(ind1),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .valid_out(valid_out), .pc_out(pc_out), .dest_out(dest_out), .result_out(result_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .ready(ready), .ind_left(ind_left)
  );

  memwb_stage_n #(.DATA_W(16), .REG_W(3), .IND_LEVELS(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .advance(adv2), .flush(flush), .valid_in(valid_in),
    .pc_in(pc_in), .dest_in(dest_in), .alu_in(alu_in), .wdata_in(wdata_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .ind_in(ind2),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .valid_out(valid_out2), .pc_out(pc_out2), .dest_out(dest_out2), .result_out(result_out2),
    .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .ready(ready2), .ind_left(ind_left2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Upstream must never advance a stage that still has an access in flight.
  task automatic tick;
    chk("upstream_adv_while_busy", {31'b0, (advance & mem_req) | (adv2 & mem_req2)}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic v, input logic [15:0] alu, input logic rd,
                         input logic wr, input logic [15:0] wd, input logic ind);
    advance = 1'b1; valid_in = v; alu_in = alu; mem_read_in = rd; mem_write_in = wr;
    wdata_in = wd; ind1 = ind; pc_in = alu + 16'h1000; dest_in = alu[2:0];
    tick();
    advance = 1'b0;
  endtask

  task automatic respond(input logic [15:0] data);
    mem_resp = 1'b1; mem_rdata = data;
    tick();
    mem_resp = 1'b0;
  endtask

  logic [15:0] exp_addr2 [3];
  logic [15:0] rvals2    [3];
  int          n;

  initial begin
    reset_n = 1'b0; advance = 1'b0; adv2 = 1'b0; flush = 1'b0; valid_in = 1'b0;
    mem_read_in = 1'b0; mem_write_in = 1'b0; mem_resp = 1'b0; pc_in = '0; alu_in = '0;
    wdata_in = '0; mem_rdata = '0; dest_in = '0; ind1 = 1'b0; ind2 = 2'd0;
    exp_addr2 = '{16'h0040, 16'h0100, 16'h0200};
    rvals2    = '{16'h0100, 16'h0200, 16'h3333};

    repeat (2) tick();
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_valid_out", {31'b0, valid_out}, 32'd0);
    chk("rst_result", {16'b0, result_out}, 32'd0);
    chk("rst_ind_left", {31'b0, ind_left}, 32'd0);
    reset_n = 1'b1;
    tick();

    // ALU op, no memory
    pc_in = 16'h0010; dest_in = 3'd3;
    advance = 1'b1; valid_in = 1'b1; alu_in = 16'h1234; mem_read_in = 1'b0; mem_write_in = 1'b0; ind1 = 1'b0;
    tick();
    advance = 1'b0;
    chk("alu_ready", {31'b0, ready}, 32'd1);
    chk("alu_result", {16'b0, result_out}, 32'h1234);
    chk("alu_pc", {16'b0, pc_out}, 32'h0010);
    chk("alu_dest", {29'b0, dest_out}, 32'd3);
    chk("alu_valid", {31'b0, valid_out}, 32'd1);
    chk("alu_no_req", {31'b0, mem_req}, 32'd0);

    // Direct load, response on the 3rd request cycle
    capture(1'b1, 16'h0040, 1'b1, 1'b0, 16'h0000, 1'b0);
    for (int c = 0; c < 3; c++) begin
      chk("ld_req", {31'b0, mem_req}, 32'd1);
      chk("ld_addr", {16'b0, mem_addr}, 32'h0040);
      chk("ld_not_ready", {31'b0, ready}, 32'd0);
      if (c < 2) tick();
    end
    respond(16'hBEEF);
    chk("ld_ready", {31'b0, ready}, 32'd1);
    chk("ld_result", {16'b0, result_out}, 32'hBEEF);
    chk("ld_req_drop", {31'b0, mem_req}, 32'd0);

    // LDI
    capture(1'b1, 16'h0040, 1'b1, 1'b0, 16'h0000, 1'b1);
    chk("ldi_addr0", {16'b0, mem_addr}, 32'h0040);
    chk("ldi_ind1", {31'b0, ind_left}, 32'd1);
    chk("ldi_we0", {31'b0, mem_we}, 32'd0);
    respond(16'h0100);
    chk("ldi_req_held", {31'b0, mem_req}, 32'd1);
    chk("ldi_addr1", {16'b0, mem_addr}, 32'h0100);
    chk("ldi_ind0", {31'b0, ind_left}, 32'd0);
    chk("ldi_we1", {31'b0, mem_we}, 32'd0);
    respond(16'h5A5A);
    chk("ldi_ready", {31'b0, ready}, 32'd1);
    chk("ldi_result", {16'b0, result_out}, 32'h5A5A);

    // STI
    capture(1'b1, 16'h0040, 1'b0, 1'b1, 16'h7777, 1'b1);
    chk("sti_ptr_we", {31'b0, mem_we}, 32'd0);
    chk("sti_ptr_addr", {16'b0, mem_addr}, 32'h0040);
    respond(16'h0200);
    chk("sti_we", {31'b0, mem_we}, 32'd1);
    chk("sti_addr", {16'b0, mem_addr}, 32'h0200);
    chk("sti_wdata", {16'b0, mem_wdata}, 32'h7777);
    chk("sti_not_ready", {31'b0, ready}, 32'd0);
    respond(16'hDEAD);
    chk("sti_ready", {31'b0, ready}, 32'd1);
    chk("sti_result", {16'b0, result_out}, 32'h0040);

    // IND_LEVELS=2 build, ind_in=3 saturates to 2
    adv2 = 1'b1; valid_in = 1'b1; alu_in = 16'h0040; mem_read_in = 1'b1; mem_write_in = 1'b0; ind2 = 2'd3;
    tick();
    adv2 = 1'b0;
    chk("sat_ind_left", {30'b0, ind_left2}, 32'd2);
    n = 0;
    while (!ready2 && n < 8) begin
      if (n < 3) chk("sat_addr", {16'b0, mem_addr2}, {16'b0, exp_addr2[n]});
      respond((n < 3) ? rvals2[n] : 16'h0000);
      n++;
    end
    chk("sat_access_count", n, 32'd3);
    chk("sat_result", {16'b0, result_out2}, 32'h3333);

    // Bubble carrying a memory flag completes with no access
    capture(1'b0, 16'h0066, 1'b1, 1'b0, 16'h0000, 1'b1);
    chk("bubble_ready", {31'b0, ready}, 32'd1);
    chk("bubble_valid", {31'b0, valid_out}, 32'd0);
    chk("bubble_no_req", {31'b0, mem_req}, 32'd0);
    chk("bubble_result", {16'b0, result_out}, 32'h0066);

    // Async reset mid-PTR
    capture(1'b1, 16'h0040, 1'b1, 1'b0, 16'h0000, 1'b1);
    chk("arst_pre_req", {31'b0, mem_req}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_req", {31'b0, mem_req}, 32'd0);
    chk("arst_addr", {16'b0, mem_addr}, 32'd0);
    chk("arst_pc", {16'b0, pc_out}, 32'd0);
    chk("arst_valid", {31'b0, valid_out}, 32'd0);
    chk("arst_ind", {31'b0, ind_left}, 32'd0);
    chk("arst_ready", {31'b0, ready}, 32'd0);
    tick();
    reset_n = 1'b1;
    respond(16'h9999);
    chk("late_resp_ready", {31'b0, ready}, 32'd0);
    chk("late_resp_result", {16'b0, result_out}, 32'd0);
    chk("late_resp_req", {31'b0, mem_req}, 32'd0);

    // Flush during PTR with a coincident response
    capture(1'b1, 16'h0040, 1'b1, 1'b0, 16'h0000, 1'b1);
    flush = 1'b1;
    respond(16'h0100);
    flush = 1'b0;
    chk("flush_valid", {31'b0, valid_out}, 32'd0);
    chk("flush_ready", {31'b0, ready}, 32'd1);
    chk("flush_req", {31'b0, mem_req}, 32'd0);
    chk("flush_addr", {16'b0, mem_addr}, 32'h0040);
    chk("flush_ind", {31'b0, ind_left}, 32'd1);

    // Advance together with flush: advance wins
    flush = 1'b1;
    capture(1'b1, 16'h0055, 1'b0, 1'b0, 16'h0000, 1'b0);
    flush = 1'b0;
    chk("advflush_valid", {31'b0, valid_out}, 32'd1);
    chk("advflush_result", {16'b0, result_out}, 32'h0055);
    chk("advflush_ready", {31'b0, ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
